dmem_arbiter: RTL

DMEM_ARBITER -- requirements
Module: dmem_arbiter

---
 rtl/dmem_arb_pkg.sv | 33 +++
 rtl/dmem_arb_rr_arb2.sv | 66 ++++++
 rtl/dmem_arbiter.sv | 188 ++++++++++++++++++
 3 files changed

// File: rtl/dmem_arb_pkg.sv
// Shared definitions for the two-port data-memory arbiter.
// Holds the FSM state encoding, port index constants, bus widths, the
// default read latency and the packed request payload carried from a
// granted port to the memory-side registers.
package dmem_arb_pkg;

  localparam int unsigned ADDR_W       = 32;
  localparam int unsigned DATA_W       = 32;
  localparam int unsigned MASK_W       = 4;
  localparam int unsigned CNT_W        = 4;
  localparam int unsigned READ_LAT_DEF = 2;

  // Port indices, also the encoding of the last_grant register
  localparam logic PORT_A = 1'b0;
  localparam logic PORT_B = 1'b1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    DONE  = 2'd3
  } state_e;

  // Request payload latched from the granted port
  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
    logic              we;
    logic [MASK_W-1:0] sign_mask;
    logic              port;
  } req_t;

endpackage

// File: rtl/dmem_arb_rr_arb2.sv
// Two-requester picker with its last_grant register.
// Build option: define DMEM_ARB_FIXED_PRIO_EN for fixed priority (A always
// wins contention, no history kept); otherwise round-robin on contention.
// Ports:
//   clk, reset_n      clock and synchronous active-low reset
//   en                picking allowed this cycle (arbiter idle, out of reset)
//   req_a, req_b      request valids of port A / port B
//   gnt_a_c, gnt_b_c  combinational one-hot grant (zero when en is low)
module rr_arb2
  import dmem_arb_pkg::*;
(
  input  logic clk,
  input  logic reset_n,
  input  logic en,
  input  logic req_a,
  input  logic req_b,
  output logic gnt_a_c,
  output logic gnt_b_c
);

`ifdef DMEM_ARB_FIXED_PRIO_EN

  // No grant history in fixed-priority mode; clock and reset are not needed
  logic unused_fixed;
  assign unused_fixed = clk ^ reset_n;

  always_comb begin
    gnt_a_c = 1'b0;
    gnt_b_c = 1'b0;
    if (en) begin
      gnt_a_c = req_a;
      gnt_b_c = req_b & ~req_a;
    end
  end

`else

  logic last_grant;

  // Contention goes to the port that did not win last time
  always_comb begin
    gnt_a_c = 1'b0;
    gnt_b_c = 1'b0;
    if (en) begin
      if (req_a && req_b) begin
        if (last_grant == PORT_B) gnt_a_c = 1'b1;
        else                      gnt_b_c = 1'b1;
      end else begin
        gnt_a_c = req_a;
        gnt_b_c = req_b;
      end
    end
  end

  // History follows every grant, contended or not
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      last_grant <= PORT_B;
    end else if (gnt_a_c || gnt_b_c) begin
      last_grant <= gnt_b_c ? PORT_B : PORT_A;
    end
  end

`endif

endmodule

// File: rtl/dmem_arbiter.sv
// Two-port (A = core, B = aux) arbiter in front of a single data memory.
// One access in flight at a time: IDLE grants, ISSUE presents the command,
// WAIT counts out the read latency, DONE returns load data to the owner.
// Build option: DMEM_ARB_FIXED_PRIO_EN selects fixed A-first priority
// (handled inside rr_arb2); default is round-robin.
// Ports:
//   clk, reset_n                 clock, synchronous active-low reset
//   a_*/b_* valid,addr,wdata,we,sign_mask   request side of each port
//   a_ready/b_ready              grant pulse, combinational in IDLE
//   a_rdata/b_rdata, a_rvalid/b_rvalid      registered load return
//   mem_addr/mem_write_data/mem_sign_mask   registered request fields
//   mem_memwrite/mem_memread     registered one-cycle command pulses
//   mem_read_data                load data, valid READ_LAT cycles after memread
module dmem_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int unsigned READ_LAT = READ_LAT_DEF
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              a_valid,
  output logic              a_ready,
  input  logic [ADDR_W-1:0] a_addr,
  input  logic [DATA_W-1:0] a_wdata,
  input  logic              a_we,
  input  logic [MASK_W-1:0] a_sign_mask,
  output logic [DATA_W-1:0] a_rdata,
  output logic              a_rvalid,
  input  logic              b_valid,
  output logic              b_ready,
  input  logic [ADDR_W-1:0] b_addr,
  input  logic [DATA_W-1:0] b_wdata,
  input  logic              b_we,
  input  logic [MASK_W-1:0] b_sign_mask,
  output logic [DATA_W-1:0] b_rdata,
  output logic              b_rvalid,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_write_data,
  output logic [MASK_W-1:0] mem_sign_mask,
  output logic              mem_memwrite,
  output logic              mem_memread,
  input  logic [DATA_W-1:0] mem_read_data
);

  state_e            state, state_nxt;
  logic [CNT_W-1:0]  cnt, cnt_nxt;
  logic              cur_port, cur_port_nxt;
  logic              cur_we, cur_we_nxt;
  logic [ADDR_W-1:0] mem_addr_nxt;
  logic [DATA_W-1:0] mem_write_data_nxt;
  logic [MASK_W-1:0] mem_sign_mask_nxt;
  logic              mem_memwrite_nxt, mem_memread_nxt;
  logic [DATA_W-1:0] a_rdata_nxt, b_rdata_nxt;
  logic              a_rvalid_nxt, b_rvalid_nxt;

  logic              arb_en_c;
  logic              gnt_a_c, gnt_b_c;
  req_t              sel_c;

  // Gating with reset_n keeps ready low while reset is asserted
  assign arb_en_c = (state == IDLE) && reset_n;

  rr_arb2 u_arb (
    .clk     (clk),
    .reset_n (reset_n),
    .en      (arb_en_c),
    .req_a   (a_valid),
    .req_b   (b_valid),
    .gnt_a_c (gnt_a_c),
    .gnt_b_c (gnt_b_c)
  );

  // Request payload of the granted port
  always_comb begin
    sel_c.addr      = a_addr;
    sel_c.wdata     = a_wdata;
    sel_c.we        = a_we;
    sel_c.sign_mask = a_sign_mask;
    sel_c.port      = PORT_A;
    if (gnt_b_c) begin
      sel_c.addr      = b_addr;
      sel_c.wdata     = b_wdata;
      sel_c.we        = b_we;
      sel_c.sign_mask = b_sign_mask;
      sel_c.port      = PORT_B;
    end
  end

  // Next-state and output logic
  always_comb begin
    state_nxt          = state;
    cnt_nxt            = cnt;
    cur_port_nxt       = cur_port;
    cur_we_nxt         = cur_we;
    mem_addr_nxt       = mem_addr;
    mem_write_data_nxt = mem_write_data;
    mem_sign_mask_nxt  = mem_sign_mask;
    mem_memwrite_nxt   = 1'b0;
    mem_memread_nxt    = 1'b0;
    a_rdata_nxt        = a_rdata;
    b_rdata_nxt        = b_rdata;
    a_rvalid_nxt       = 1'b0;
    b_rvalid_nxt       = 1'b0;
    a_ready            = 1'b0;
    b_ready            = 1'b0;

    case (state)
      IDLE: begin
        if (gnt_a_c || gnt_b_c) begin
          a_ready            = gnt_a_c;
          b_ready            = gnt_b_c;
          cur_port_nxt       = sel_c.port;
          cur_we_nxt         = sel_c.we;
          mem_addr_nxt       = sel_c.addr;
          mem_write_data_nxt = sel_c.wdata;
          mem_sign_mask_nxt  = sel_c.sign_mask;
          // Command pulse is registered here so it is visible during ISSUE
          mem_memwrite_nxt   = sel_c.we;
          mem_memread_nxt    = ~sel_c.we;
          state_nxt          = ISSUE;
        end
      end

      ISSUE: begin
        if (cur_we) begin
          state_nxt = IDLE;
        end else begin
          cnt_nxt   = CNT_W'(READ_LAT);
          // With a one-cycle latency the data is already due in the next cycle
          state_nxt = (READ_LAT <= 1) ? DONE : WAIT;
        end
      end

      WAIT: begin
        cnt_nxt = cnt - CNT_W'(1);
        if (cnt <= CNT_W'(2)) state_nxt = DONE;
      end

      DONE: begin
        if (cur_port == PORT_A) begin
          a_rdata_nxt  = mem_read_data;
          a_rvalid_nxt = 1'b1;
        end else begin
          b_rdata_nxt  = mem_read_data;
          b_rvalid_nxt = 1'b1;
        end
        cnt_nxt   = '0;
        state_nxt = IDLE;
      end

      default: state_nxt = IDLE;
    endcase
  end

  // State and output registers
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state          <= IDLE;
      cnt            <= '0;
      cur_port       <= PORT_A;
      cur_we         <= 1'b0;
      mem_addr       <= '0;
      mem_write_data <= '0;
      mem_sign_mask  <= '0;
      mem_memwrite   <= 1'b0;
      mem_memread    <= 1'b0;
      a_rdata        <= '0;
      b_rdata        <= '0;
      a_rvalid       <= 1'b0;
      b_rvalid       <= 1'b0;
    end else begin
      state          <= state_nxt;
      cnt            <= cnt_nxt;
      cur_port       <= cur_port_nxt;
      cur_we         <= cur_we_nxt;
      mem_addr       <= mem_addr_nxt;
      mem_write_data <= mem_write_data_nxt;
      mem_sign_mask  <= mem_sign_mask_nxt;
      mem_memwrite   <= mem_memwrite_nxt;
      mem_memread    <= mem_memread_nxt;
      a_rdata        <= a_rdata_nxt;
      b_rdata        <= b_rdata_nxt;
      a_rvalid       <= a_rvalid_nxt;
      b_rvalid       <= b_rvalid_nxt;
    end
  end

endmodule
